// File: rtl/goldcrest_pkg.sv
// Shared fetch-stage types and constants.
package goldcrest_pkg;

  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // One buffered fetch result: instruction word and the address it came from.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [ILEN-1:0] pc;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [ILEN-1:0] word_align(input logic [ILEN-1:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order instruction buffer between fetch and decode.
module fetch_fifo
  import goldcrest_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  fetch_entry_t  wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and occupancy; flush empties the buffer in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential prefetch into a small buffer, with redirect
// handling that discards responses already in flight.
module instr_fetch
  import goldcrest_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e  state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] os_q, os_d;        // live responses still owed by memory
  logic [CW-1:0] disc_q, disc_d;    // stale responses to swallow
  logic          armed_q;           // set by first grant after reset

  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;
  fetch_entry_t  head, wentry;
  logic          req, fire, rsp_ok, push, pop;

  // Room is counted against both buffered words and words still owed, so a
  // granted request always has a slot waiting for its response.
  assign req    = (state_q == RUN) && fetch_en_i &&
                  ((32'(os_q) + 32'(fifo_cnt)) < FIFO_DEPTH);
  assign fire   = req && imem_gnt_i;
  assign rsp_ok = imem_rvalid_i && armed_q;
  assign push   = rsp_ok && (disc_q == '0) && !redirect_i;
  assign pop    = !fifo_empty && instr_ready_i && !redirect_i;

  assign wentry.instr = imem_rdata_i;
  // Responses return in order and stale ones are discarded first, so the
  // oldest live request address is fetch_pc minus the live count.
  assign wentry.pc    = fetch_pc_q - {os_q, 2'b00};

  // Outstanding / discard bookkeeping; a redirect turns everything in flight
  // (including a same-cycle grant) into discards.
  always_comb begin
    os_d   = os_q;
    disc_d = disc_q;
    if (redirect_i) begin
      os_d   = '0;
      disc_d = CW'(32'(disc_q) + 32'(os_q) + 32'(fire) - 32'(rsp_ok));
    end else begin
      if (rsp_ok && disc_q != '0) disc_d = disc_q - 1'b1;
      os_d = CW'(32'(os_q) + 32'(fire) - 32'(rsp_ok && disc_q == '0));
    end
  end

  // Next fetch address: redirect target wins over sequential advance.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i)  fetch_pc_d = word_align(redirect_pc_i);
    else if (fire)   fetch_pc_d = fetch_pc_q + 32'd4;
  end

  // Fetch control state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else if (redirect_i && disc_d != '0) begin
      state_q <= DRAIN;
    end else begin
      case (state_q)
        IDLE:    if (fetch_en_i) state_q <= RUN;
        RUN:     if (!fetch_en_i) state_q <= IDLE;
        DRAIN:   if (disc_d == '0) state_q <= fetch_en_i ? RUN : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Fetch address and in-flight counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= BOOT_ADDR;
      os_q       <= '0;
      disc_q     <= '0;
      armed_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      os_q       <= os_d;
      disc_q     <= disc_d;
      if (fire) armed_q <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign imem_req_o    = req;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = head.instr;
  assign pc_o          = head.pc;

  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_ok |-> (os_q != '0 || disc_q != '0));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch with a queue-based memory and decode model.
module tb_instr_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  always #5 clk_i = ~clk_i;

  instr_fetch #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_en_i    (fetch_en_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } rsp_t;

  rsp_t        mq[$];       // memory: granted requests awaiting response
  logic [31:0] mf[$];       // expected buffer contents (addresses)
  logic [31:0] req_log[$];  // granted request addresses
  logic [31:0] acc_log[$];  // addresses accepted by decode
  logic [31:0] exp_req;
  int          cyc, checks, errors, occ_max, nfire, nacc;
  bit          en, redir_pend, drain_done, en_prev;
  int          rdy_pct, gnt_pct, rv_pct, lat_lo, lat_hi;
  logic [31:0] redir_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mq[i]) if (mq[i].stale) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step();
    bit   rv, fire, pop, red;
    int   st_n, live_n;
    rsp_t r;
    @(negedge clk_i);
    cyc++;
    fetch_en_i    = en;
    instr_ready_i = ($urandom_range(99) < rdy_pct);
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    red           = redir_pend;
    redirect_i    = red;
    redirect_pc_i = redir_tgt;
    redir_pend    = 1'b0;
    rv = (mq.size() > 0) && (mq[0].due <= cyc) && ($urandom_range(99) < rv_pct);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(mq[0].addr) : $urandom;
    #1;
    st_n   = stale_cnt();
    live_n = mq.size() - st_n;
    if (live_n + mf.size() > occ_max) occ_max = live_n + mf.size();

    chk("valid", instr_valid_o, mf.size() != 0);
    if (mf.size() != 0) begin
      chk("pc", pc_o, mf[0]);
      chk("instr", instr_o, mem_word(mf[0]));
    end
    if (imem_req_o) chk("req_addr", imem_addr_o, exp_req);
    if (st_n > 0 || live_n + mf.size() >= DEPTH || !en) chk("req_blocked", imem_req_o, 0);
    if (drain_done && en && en_prev) chk("req_after_drain", imem_req_o, 1);

    fire = imem_req_o && imem_gnt_i;
    pop  = instr_valid_o && instr_ready_i && !red;
    if (fire) begin req_log.push_back(imem_addr_o); nfire++; end
    if (pop) begin acc_log.push_back(pc_o); nacc++; void'(mf.pop_front()); end
    drain_done = 1'b0;
    if (red) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      mf.delete();
    end
    if (rv) begin
      r = mq.pop_front();
      if (!r.stale) mf.push_back(r.addr);
      else if (!red && st_n == 1) drain_done = 1'b1;
    end
    if (fire) mq.push_back('{exp_req, red, cyc + 1 + int'($urandom_range(lat_hi, lat_lo))});
    if (red)       exp_req = redir_tgt & ~32'h3;
    else if (fire) exp_req = exp_req + 32'd4;
    en_prev = en;
  endtask

  // Assert reset, check outputs right away, then release.
  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_addr", imem_addr_o, BOOT);
    mq.delete(); mf.delete();
    exp_req = BOOT; drain_done = 1'b0; en_prev = 1'b0;
    imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0; redirect_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; occ_max = 0; nfire = 0; nacc = 0;
    en = 1'b1; rdy_pct = 100; gnt_pct = 100; rv_pct = 100; lat_lo = 0; lat_hi = 0;
    redir_pend = 1'b0; redir_tgt = '0; drain_done = 1'b0; en_prev = 1'b0; exp_req = BOOT;

    // Boot with zero-wait memory: sequential requests and deliveries.
    do_reset();
    req_log.delete(); acc_log.delete();
    repeat (12) step();
    chk("t1_nreq", req_log.size() >= 3, 1);
    chk("t1_nacc", acc_log.size() >= 3, 1);
    if (req_log.size() >= 3 && acc_log.size() >= 3)
      for (int k = 0; k < 3; k++) begin
        chk("t1_req", req_log[k], 32'(k * 4));
        chk("t1_pc", acc_log[k], 32'(k * 4));
      end

    // Decode stall: occupancy must cap at the buffer depth.
    rdy_pct = 0; occ_max = 0; nfire = 0;
    repeat (10) step();
    chk("t2_occ_max", occ_max, DEPTH);
    chk("t2_nfire", nfire <= DEPTH, 1);
    rdy_pct = 100; acc_log.delete();
    repeat (10) step();
    chk("t2_resume", acc_log.size() >= 4, 1);

    // Redirect with two responses in flight.
    lat_lo = 3; lat_hi = 3;
    for (int k = 0; k < 20 && mq.size() != DEPTH; k++) step();
    chk("t3_inflight", mq.size(), DEPTH);
    rv_pct = 0; redir_pend = 1'b1; redir_tgt = 32'h100;
    step();
    chk("t3_discards", stale_cnt(), 2);
    rv_pct = 100; req_log.delete(); acc_log.delete();
    for (int k = 0; k < 40 && acc_log.size() == 0; k++) step();
    chk("t3_nacc", acc_log.size() >= 1, 1);
    if (acc_log.size() >= 1) begin
      chk("t3_first_req", req_log[0], 32'h100);
      chk("t3_first_pc", acc_log[0], 32'h100);
    end

    // Misaligned redirect target.
    lat_lo = 0; lat_hi = 2;
    redir_pend = 1'b1; redir_tgt = 32'h203;
    step();
    req_log.delete();
    for (int k = 0; k < 40 && req_log.size() == 0; k++) step();
    chk("t4_nreq", req_log.size() >= 1, 1);
    if (req_log.size() >= 1) chk("t4_align", req_log[0], 32'h200);

    // Address wrap at the top of the address space.
    redir_pend = 1'b1; redir_tgt = 32'hFFFF_FFFC;
    step();
    req_log.delete();
    for (int k = 0; k < 40 && req_log.size() < 2; k++) step();
    chk("t5_nreq", req_log.size() >= 2, 1);
    if (req_log.size() >= 2) begin
      chk("t5_top", req_log[0], 32'hFFFF_FFFC);
      chk("t5_wrap", req_log[1], 32'h0000_0000);
    end

    // Random traffic against the model.
    nacc = 0;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(99) < 92);
      rdy_pct = 70; gnt_pct = 60; rv_pct = 70; lat_lo = 0; lat_hi = 4;
      if ($urandom_range(99) < 3) begin
        redir_pend = 1'b1;
        redir_tgt  = $urandom;
      end
      step();
    end
    chk("t6_progress", nacc >= 100, 1);

    // Reset in the middle of a drain.
    en = 1'b1; rdy_pct = 100; gnt_pct = 100; rv_pct = 100; lat_lo = 3; lat_hi = 3;
    for (int k = 0; k < 60 && !(mq.size() == DEPTH && stale_cnt() == 0); k++) step();
    chk("t7_inflight", mq.size(), DEPTH);
    rv_pct = 0; redir_pend = 1'b1; redir_tgt = 32'h400;
    step();
    step();
    chk("t7_draining", stale_cnt(), 2);
    do_reset();
    rv_pct = 100; req_log.delete(); acc_log.delete();
    for (int k = 0; k < 30 && acc_log.size() == 0; k++) step();
    chk("t7_nacc", acc_log.size() >= 1, 1);
    if (acc_log.size() >= 1) begin
      chk("t7_restart_req", req_log[0], BOOT);
      chk("t7_restart_pc", acc_log[0], BOOT);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
